// File: rtl/snake_pkg.sv
// Shared types for the snake motion engine: movement directions, grid cell
// coordinates and the direction-reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  localparam int SNAKE_GRID_W = 16;
  localparam int SNAKE_GRID_H = 16;
  localparam int POS_XW       = $clog2(SNAKE_GRID_W);
  localparam int POS_YW       = $clog2(SNAKE_GRID_H);

  typedef struct packed {
    logic [POS_XW-1:0] x;
    logic [POS_YW-1:0] y;
  } pos_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      opposite = DOWN;
      DOWN:    opposite = UP;
      LEFT:    opposite = RIGHT;
      default: opposite = LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_speed_tick.sv
// Move-rate generator: one-cycle tick every period clocks while enabled.
// The period is latched whenever the count restarts, so difficulty changes apply from the next period.
module snake_speed_tick #(
  parameter int TICK_NORMAL = 12_500_000,
  parameter int TICK_HARD   = 6_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic difficulty,
  output logic tick
);

  localparam int MAXP = (TICK_NORMAL > TICK_HARD) ? TICK_NORMAL : TICK_HARD;
  localparam int CW   = (MAXP > 2) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] LAST_N = CW'(TICK_NORMAL - 1);
  localparam logic [CW-1:0] LAST_H = CW'(TICK_HARD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d;

  assign tick = enable && (cnt_q == last_q);

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    last_d = last_q;
    if (!enable || tick) begin
      cnt_d  = '0;
      last_d = difficulty ? LAST_H : LAST_N;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      last_q <= difficulty ? LAST_H : LAST_N;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/snake_motion_engine.sv
// Snake state owner: direction, segment buffer and length; moves one cell per
// speed tick, flags wall/self/food contact and answers a registered occupancy query.
module snake_motion_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = SNAKE_GRID_W,
  parameter int GRID_H      = SNAKE_GRID_H,
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 3,
  parameter int TICK_NORMAL = 12_500_000,
  parameter int TICK_HARD   = 6_250_000,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          run,
  input  logic          difficulty,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  input  logic          food_valid,
  input  logic [XW-1:0] qry_x,
  input  logic [YW-1:0] qry_y,
  output logic          qry_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          food_collision,
  output logic          game_over
);

  localparam logic [YW-1:0]        HOME_Y = YW'(GRID_H / 2);
  localparam logic signed [XW+1:0] X_LAST = (XW+2)'(GRID_W - 1);
  localparam logic signed [YW+1:0] Y_LAST = (YW+2)'(GRID_H - 1);

  dir_t          dir_q, dir_d, pend_q, pend_d, cur_dir;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d, lim;
  logic          fc_q, fc_d, go_q, go_d, qhit_q, qhit_d;
  logic          tick;

  logic signed [XW+1:0] dx, nx;
  logic signed [YW+1:0] dy, ny;
  logic [XW-1:0]        next_x;
  logic [YW-1:0]        next_y;
  logic                 wall_hit, self_hit, eat;

  snake_speed_tick #(
    .TICK_NORMAL (TICK_NORMAL),
    .TICK_HARD   (TICK_HARD)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable     (run && !go_q),
    .difficulty (difficulty),
    .tick       (tick)
  );

  // On a tick the pending direction becomes current, so reversal is judged against it.
  always_comb begin
    cur_dir = tick ? pend_q : dir_q;
    dir_d   = cur_dir;
    pend_d  = pend_q;
    if (!btn_right && opposite(cur_dir) != RIGHT) pend_d = RIGHT;
    if (!btn_left  && opposite(cur_dir) != LEFT)  pend_d = LEFT;
    if (!btn_down  && opposite(cur_dir) != DOWN)  pend_d = DOWN;
    if (!btn_up    && opposite(cur_dir) != UP)    pend_d = UP;
  end

  always_comb begin
    dx = '0;
    dy = '0;
    case (pend_q)
      UP:      dy = '1;
      DOWN:    dy = {{(YW+1){1'b0}}, 1'b1};
      LEFT:    dx = '1;
      default: dx = {{(XW+1){1'b0}}, 1'b1};
    endcase
    nx       = $signed({2'b00, seg_x_q[0]}) + dx;
    ny       = $signed({2'b00, seg_y_q[0]}) + dy;
    next_x   = nx[XW-1:0];
    next_y   = ny[YW-1:0];
    wall_hit = nx[XW+1] || ny[YW+1] || (nx > X_LAST) || (ny > Y_LAST);
    eat      = food_valid && (next_x == food_x) && (next_y == food_y);
    // The tail cell is vacated this move unless the snake grows.
    lim      = eat ? len_q : len_q - 1'b1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < lim && seg_x_q[i] == next_x && seg_y_q[i] == next_y) self_hit = 1'b1;
    end
  end

  always_comb begin
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    len_d   = len_q;
    fc_d    = 1'b0;
    go_d    = go_q;
    if (tick) begin
      if (wall_hit || self_hit) begin
        go_d = 1'b1;
      end else begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = next_x;
        seg_y_d[0] = next_y;
        if (eat) begin
          fc_d = 1'b1;
          if (len_q < LW'(MAX_LEN)) len_d = len_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    qhit_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_q && seg_x_q[i] == qry_x && seg_y_q[i] == qry_y) qhit_d = 1'b1;
    end
  end

  // init reloads the same starting snake as reset and wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst || init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= XW'(GRID_W / 2 - i);
        seg_y_q[i] <= HOME_Y;
      end
      len_q  <= LW'(INIT_LEN);
      dir_q  <= RIGHT;
      pend_q <= RIGHT;
      fc_q   <= 1'b0;
      go_q   <= 1'b0;
      qhit_q <= 1'b0;
    end else begin
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      fc_q    <= fc_d;
      go_q    <= go_d;
      qhit_q  <= qhit_d;
    end
  end

  assign head_x         = seg_x_q[0];
  assign head_y         = seg_y_q[0];
  assign length         = len_q;
  assign food_collision = fc_q;
  assign game_over      = go_q;
  assign qry_hit        = qhit_q;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Bench for snake_motion_engine: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based behavioural snake model.
module tb_snake_motion_engine;

  localparam int GW = 16;
  localparam int GH = 16;
  localparam int ML = 16;
  localparam int IL = 3;
  localparam int TN = 4;
  localparam int TH = 2;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst, init, run, difficulty;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [3:0] food_x, food_y, qry_x, qry_y;
  logic       food_valid, qry_hit, food_collision, game_over;
  logic [3:0] head_x, head_y;
  logic [4:0] length;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_motion_engine #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL),
    .TICK_NORMAL(TN), .TICK_HARD(TH)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .run(run), .difficulty(difficulty),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .qry_x(qry_x), .qry_y(qry_y), .qry_hit(qry_hit),
    .head_x(head_x), .head_y(head_y), .length(length),
    .food_collision(food_collision), .game_over(game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int hx, input int hy,
                             input int len, input int fc, input int go);
    chk({tag, "_head_x"}, int'(head_x), hx);
    chk({tag, "_head_y"}, int'(head_y), hy);
    chk({tag, "_length"}, int'(length), len);
    chk({tag, "_food_collision"}, int'(food_collision), fc);
    chk({tag, "_game_over"}, int'(game_over), go);
  endtask

  task automatic set_btn(input logic [3:0] p);
    btn_up    = ~p[3];
    btn_down  = ~p[2];
    btn_left  = ~p[1];
    btn_right = ~p[0];
  endtask

  task automatic step(input logic [3:0] b, input int n);
    set_btn(b);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic diff);
    difficulty = diff;
    food_valid = 1'b0;
    set_btn(B_NONE);
    run  = 1'b0;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    run  = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int x;
    int y;
  } cell_t;

  cell_t body[$];
  int    m_dir, m_pend, m_cnt, m_per;
  bit    m_go, m_fc, m_qhit;

  function automatic int opp(input int d);
    return d ^ 1;  // 0 up, 1 down, 2 left, 3 right
  endfunction

  function automatic bit occupied(input int x, input int y);
    foreach (body[i]) if (body[i].x == x && body[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_init();
    body.delete();
    for (int i = 0; i < IL; i++) body.push_back('{GW / 2 - i, GH / 2});
    m_dir  = 3;
    m_pend = 3;
    m_go   = 1'b0;
    m_fc   = 1'b0;
    m_qhit = 1'b0;
  endtask

  task automatic model_step();
    bit en, tk, eat, hit, qh;
    int cur, npend, nx, ny, lim;
    logic [3:0] pr;
    if (!rst) begin
      m_cnt = 0;
      m_per = difficulty ? TH : TN;
      model_init();
      return;
    end
    en = run && !m_go;
    tk = en && (m_cnt == m_per - 1);
    if (!en || tk) begin
      m_cnt = 0;
      m_per = difficulty ? TH : TN;
    end else begin
      m_cnt++;
    end
    qh = occupied(int'(qry_x), int'(qry_y));
    if (init) begin
      model_init();
      return;
    end
    cur   = tk ? m_pend : m_dir;
    pr    = {~btn_up, ~btn_down, ~btn_left, ~btn_right};
    npend = m_pend;
    for (int d = 0; d < 4; d++) begin
      if (pr[3-d] && d != opp(cur)) begin
        npend = d;
        break;
      end
    end
    m_fc = 1'b0;
    if (tk) begin
      m_dir = m_pend;
      nx = body[0].x;
      ny = body[0].y;
      case (m_pend)
        0:       ny = ny - 1;
        1:       ny = ny + 1;
        2:       nx = nx - 1;
        default: nx = nx + 1;
      endcase
      hit = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
      eat = 1'b0;
      if (!hit) begin
        eat = food_valid && nx == int'(food_x) && ny == int'(food_y);
        lim = eat ? body.size() : body.size() - 1;
        for (int i = 0; i < lim; i++) if (body[i].x == nx && body[i].y == ny) hit = 1'b1;
      end
      if (hit) begin
        m_go = 1'b1;
      end else begin
        body.push_front('{nx, ny});
        if (!eat || body.size() > ML) void'(body.pop_back());
        m_fc = eat;
      end
    end
    m_pend = npend;
    m_qhit = qh;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         nclk;
    logic [3:0] btn;
    bit         fv;
    int         fx, fy, qx, qy;
    int         ehx, ehy, elen;
    bit         efc, ego, eqh;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b0; init = 1'b0; run = 1'b0; difficulty = 1'b0;
    set_btn(B_NONE);
    food_x = 4'd0; food_y = 4'd0; food_valid = 1'b0;
    qry_x = 4'd8; qry_y = 4'd8;

    vecs[0] = '{4, B_NONE,  1'b0,  0, 0,  8, 8,   9, 8, 3,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{1, B_LEFT,  1'b0,  0, 0,  6, 8,   9, 8, 3,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{3, B_NONE,  1'b0,  0, 0,  7, 8,  10, 8, 3,  1'b0, 1'b0, 1'b1};
    vecs[3] = '{4, B_UP,    1'b0,  0, 0, 10, 8,  10, 7, 3,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{4, B_RIGHT, 1'b1, 11, 7, 11, 7,  11, 7, 4,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, B_NONE,  1'b0, 11, 7,  9, 8,  11, 7, 4,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{3, B_NONE,  1'b0, 11, 7,  9, 8,  12, 7, 4,  1'b0, 1'b0, 1'b1};
    vecs[7] = '{1, B_NONE,  1'b0, 11, 7,  9, 8,  12, 7, 4,  1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8, 8, 3, 0, 0);
    chk("reset_qry_hit", int'(qry_hit), 0);
    rst = 1'b1;
    run = 1'b1;

    for (int k = 0; k < 8; k++) begin
      food_valid = vecs[k].fv;
      food_x     = 4'(vecs[k].fx);
      food_y     = 4'(vecs[k].fy);
      qry_x      = 4'(vecs[k].qx);
      qry_y      = 4'(vecs[k].qy);
      step(vecs[k].btn, vecs[k].nclk);
      check_state($sformatf("vec%0d", k), vecs[k].ehx, vecs[k].ehy, vecs[k].elen,
                  int'(vecs[k].efc), int'(vecs[k].ego));
      chk($sformatf("vec%0d_qry_hit", k), int'(qry_hit), int'(vecs[k].eqh));
    end

    // Right wall: no wrap, head frozen, game_over held across run toggling.
    restart(1'b0);
    step(B_NONE, 28);
    check_state("wall_pre", 15, 8, 3, 0, 0);
    step(B_NONE, 4);
    check_state("wall_hit", 15, 8, 3, 0, 1);
    step(B_NONE, 8);
    check_state("wall_hold", 15, 8, 3, 0, 1);
    run = 1'b0;
    step(B_NONE, 1);
    run = 1'b1;
    step(B_NONE, 4);
    check_state("wall_runtoggle", 15, 8, 3, 0, 1);
    restart(1'b0);
    check_state("wall_init", 8, 8, 3, 0, 0);

    // Grow to length 5, then turn back into the body.
    restart(1'b0);
    food_valid = 1'b1; food_x = 4'd9; food_y = 4'd8;
    step(B_NONE, 4);
    check_state("self_eat1", 9, 8, 4, 1, 0);
    food_x = 4'd10;
    step(B_NONE, 4);
    check_state("self_eat2", 10, 8, 5, 1, 0);
    food_valid = 1'b0;
    step(B_UP, 4);
    step(B_LEFT, 4);
    check_state("self_pre", 9, 7, 5, 0, 0);
    step(B_DOWN, 4);
    check_state("self_hit", 9, 7, 5, 0, 1);

    // Length 4 loop: the head enters the cell the tail leaves on the same move.
    restart(1'b0);
    food_valid = 1'b1; food_x = 4'd9; food_y = 4'd8;
    step(B_NONE, 4);
    food_valid = 1'b0;
    step(B_UP, 4);
    step(B_LEFT, 4);
    step(B_DOWN, 4);
    check_state("tail_follow", 8, 8, 4, 0, 0);

    // Hard difficulty: one move every 2 clocks.
    restart(1'b1);
    step(B_NONE, 1);
    check_state("hard_1clk", 8, 8, 3, 0, 0);
    step(B_NONE, 1);
    check_state("hard_2clk", 9, 8, 3, 0, 0);
    step(B_NONE, 2);
    check_state("hard_4clk", 10, 8, 3, 0, 0);

    // init coinciding with a tick: starting snake loaded, no move.
    step(B_NONE, 1);
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    check_state("init_tick", 8, 8, 3, 0, 0);
    step(B_NONE, 2);
    check_state("init_tick_next", 9, 8, 3, 0, 0);

    // Randomized run against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst  = (cyc == 0) ? 1'b0 : ($urandom_range(0, 999) != 0);
      init = m_go ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      run  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) difficulty = ~difficulty;
      btn_up    = ($urandom_range(0, 9) != 0);
      btn_down  = ($urandom_range(0, 9) != 0);
      btn_left  = ($urandom_range(0, 9) != 0);
      btn_right = ($urandom_range(0, 9) != 0);
      if (cyc > 0 && $urandom_range(0, 5) == 0) begin
        food_x = 4'((body[0].x + int'($urandom_range(0, 2)) - 1) & 15);
        food_y = 4'((body[0].y + int'($urandom_range(0, 2)) - 1) & 15);
      end
      food_valid = ($urandom_range(0, 3) != 0);
      if (cyc > 0 && $urandom_range(0, 1) == 0) begin
        qry_x = 4'(body[$urandom_range(0, body.size() - 1)].x & 15);
        qry_y = 4'(body[0].y & 15);
      end else begin
        qry_x = 4'($urandom_range(0, 15));
        qry_y = 4'($urandom_range(0, 15));
      end
      model_step();
      @(posedge clk);
      #1;
      chk("rand_head_x", int'(head_x), body[0].x);
      chk("rand_head_y", int'(head_y), body[0].y);
      chk("rand_length", int'(length), body.size());
      chk("rand_food_collision", int'(food_collision), int'(m_fc));
      chk("rand_game_over", int'(game_over), int'(m_go));
      chk("rand_qry_hit", int'(qry_hit), int'(m_qhit));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_motion_engine.md
Name: snake_motion_engine

Overview:
- Upstream producer of the game-control FSM's `food_collision` and `game_over` inputs.
- Owns snake state: direction, segment buffer and length.
- Advances the snake one cell per speed tick; the tick rate follows the FSM's `difficulty` output.
- Detects wall, self and food contact. Also serves a registered occupancy query for the VGA renderer and food placer.

Parameters:
- GRID_W, 16, grid width in cells (x in 0..GRID_W-1)
- GRID_H, 16, grid height in cells (y in 0..GRID_H-1)
- MAX_LEN, 16, segment buffer depth / maximum length
- INIT_LEN, 3, length after init (2..MAX_LEN)
- TICK_NORMAL, 12_500_000, clocks per move at difficulty=0
- TICK_HARD, 6_250_000, clocks per move at difficulty=1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- init  in  1  start-of-game pulse (driven by FSM rst_game)
- run  in  1  game active (FSM stage); motion only when 1
- difficulty  in  1  0 normal, 1 hard
- btn_up, btn_down, btn_left, btn_right  in  1 each  direction buttons, active-low, already synchronised
- food_x  in  $clog2(GRID_W)  food column
- food_y  in  $clog2(GRID_H)  food row
- food_valid  in  1  food present on grid
- qry_x, qry_y  in  coord widths  occupancy query cell
- qry_hit  out  1  query cell holds a segment (1-cycle latency)
- head_x, head_y  out  coord widths  current head
- length  out  $clog2(MAX_LEN+1)  current length
- food_collision  out  1  one-cycle pulse: head entered food cell
- game_over  out  1  level: wall/self hit, held until init

Behaviour:
- Reset (rst=0 at a clk edge):
  - head=(GRID_W/2, GRID_H/2), length=INIT_LEN, dir=RIGHT.
  - seg[i]=(GRID_W/2-i, GRID_H/2).
  - food_collision=0, game_over=0, qry_hit=0, tick counter=0.
- init=1 loads the same state as reset. init has priority over a tick in the same cycle.
- Tick generator:
  - Counts while run=1 and game_over=0; otherwise the count is held at 0.
  - Asserts `tick` for one cycle when count==period-1, then wraps to 0.
  - period = difficulty ? TICK_HARD : TICK_NORMAL, sampled at wrap. A difficulty change takes effect from the next period.
- Direction: any cycle, a pressed button (value 0) updates pending_dir.
  - Priority up>down>left>right.
  - A button opposite to the current dir is ignored.
  - dir<=pending_dir on tick.
- Move on tick, computed combinationally from pending_dir:
  - next = head + delta.
  - Wall hit if next would leave 0..GRID_W-1 or 0..GRID_H-1. Detect before truncation; no wrap-around.
  - eat = food_valid && next==(food_x,food_y).
  - Self hit if next equals any seg[i] with i < (eat ? length : length-1), since the tail vacates when not eating.
  - Wall or self hit: game_over<=1, no segment or length update, food_collision stays 0. Game-over has priority over eat.
  - Otherwise: seg[i]<=seg[i-1], seg[0]<=next. If eat: length<=min(length+1, MAX_LEN) and food_collision<=1 for exactly the next cycle.
  - At MAX_LEN the pulse still fires and the length saturates.
- Outputs are registered. head/length/food_collision/game_over change on the edge after the tick cycle (latency 1).
- game_over remains 1 while run toggles; it clears only on init or rst. No movement while game_over=1.
- qry_hit: registered OR over i<length of (seg[i]==qry), updated every cycle.
- Segments at index ≥ length are don't-care and never match.

Decomposition:
- snake_pkg:
  - dir_t enum {UP, DOWN, LEFT, RIGHT}
  - pos_t struct {x, y}
  - GRID_W/GRID_H defaults
  - opposite(dir) function
- One sub-module: snake_speed_tick (counter + period mux; inputs clk, rst, enable, difficulty; output tick).

Test Plan:
- Reset, run=1, difficulty=0, TICK_NORMAL=4 (override) → head (8,8)→(9,8) after 4 clk; length=3; game_over=0.
- Head (9,8), press btn_left while moving RIGHT → ignored. Press btn_up → next tick head=(9,7).
- Food at (10,8), food_valid=1, dir RIGHT → food_collision high exactly 1 cycle; length 3→4; tail unchanged that tick.
- Run right from (8,8) with GRID_W=16 → after 7 moves head=(15,8); next tick game_over=1, head stays (15,8). Then init → state back to reset values.
- Length 5, steer into own body → game_over=1. Separately, at length 4 enter the cell the tail leaves that tick → no game_over.
- difficulty=1, TICK_HARD=2 → a move every 2 clk. init and tick in the same cycle → init state loaded, no move.
